// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan
// Description : Four-digit multiplexed seven-segment scanner. A prescaler
//               divides display_clk into digit slots; a frame register
//               captures BCD once per frame so a scan never tears. Drives
//               active-low anodes and cathodes with optional leading-zero
//               blanking and a dash glyph for non-decimal nibbles.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        display_clk,
    input  logic        RST,
    input  logic [15:0] BCD,
    input  logic        LZB,
    output logic [3:0]  DIGIT,
    output logic [7:0]  SEGMENT,
    output logic        FRAME_TICK
);

    localparam logic [15:0] C_CNT_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  C_SEG_OFF  = 8'hFF;
    localparam logic [7:0]  C_SEG_DASH = 8'hBF;

    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic [15:0] r_frame;

    logic        w_tick;
    logic        w_load;
    logic [3:0]  w_nib;
    logic        w_zero_above;
    logic [7:0]  w_seg;

    // Active-low glyph for one nibble; dp (bit 7) is always off.
    function automatic logic [7:0] f_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = C_SEG_DASH;
        endcase
        return seg;
    endfunction

    assign w_tick = (r_cnt == C_CNT_LAST);
    assign w_load = (r_cnt == 16'd0) && (r_idx == 2'd0);

    // Select the current slot's nibble and check whether it and every more
    // significant digit are zero (slot 0 is never a blanking candidate).
    always_comb begin
        w_nib        = r_frame[3:0];
        w_zero_above = 1'b0;
        case (r_idx)
            2'd1: begin
                w_nib        = r_frame[7:4];
                w_zero_above = (r_frame[15:4] == 12'd0);
            end
            2'd2: begin
                w_nib        = r_frame[11:8];
                w_zero_above = (r_frame[15:8] == 8'd0);
            end
            2'd3: begin
                w_nib        = r_frame[15:12];
                w_zero_above = (r_frame[15:12] == 4'd0);
            end
            default: begin
                w_nib        = r_frame[3:0];
                w_zero_above = 1'b0;
            end
        endcase
        w_seg = (LZB && w_zero_above) ? C_SEG_OFF : f_decode(w_nib);
    end

    // Prescaler, slot index, frame capture and registered display outputs.
    always_ff @(posedge display_clk) begin
        if (RST) begin
            r_cnt      <= 16'd0;
            r_idx      <= 2'd0;
            r_frame    <= 16'd0;
            DIGIT      <= 4'b1111;
            SEGMENT    <= C_SEG_OFF;
            FRAME_TICK <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cnt <= 16'd0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_load) begin
                r_frame <= BCD;
            end
            FRAME_TICK <= w_load;
            DIGIT      <= ~(4'b0001 << r_idx);
            SEGMENT    <= w_seg;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan
// Description : Self-checking bench for seg_scan. A cycle-count model derives
//               expected outputs every cycle; directed scenarios add literal
//               expectations at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan;

    localparam int SD = 4;

    logic        clk;
    logic        RST;
    logic [15:0] BCD;
    logic        LZB;
    logic [3:0]  DIGIT;
    logic [7:0]  SEGMENT;
    logic        FRAME_TICK;

    int vectors     = 0;
    int miscompares = 0;

    seg_scan #(.SCAN_DIV(SD)) dut (
        .display_clk (clk),
        .RST         (RST),
        .BCD         (BCD),
        .LZB         (LZB),
        .DIGIT       (DIGIT),
        .SEGMENT     (SEGMENT),
        .FRAME_TICK  (FRAME_TICK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] glyph [16];
    initial begin
        glyph[0] = 8'hC0; glyph[1] = 8'hF9; glyph[2] = 8'hA4; glyph[3] = 8'hB0;
        glyph[4] = 8'h99; glyph[5] = 8'h92; glyph[6] = 8'h82; glyph[7] = 8'hF8;
        glyph[8] = 8'h80; glyph[9] = 8'h90;
        for (int i = 10; i < 16; i++) glyph[i] = 8'hBF;
    end

    int         n;          // edges since reset was released
    logic [15:0] m_frame;
    logic [3:0]  exp_digit;
    logic [7:0]  exp_seg;
    logic        exp_tick;
    bit          started = 0;

    // Outputs at edge n show the slot and frame as they stood before that edge.
    always @(posedge clk) begin
        int slot;
        started = 1;
        if (RST) begin
            n         = 0;
            m_frame   = 16'h0;
            exp_digit = 4'hF;
            exp_seg   = 8'hFF;
            exp_tick  = 1'b0;
        end else begin
            slot      = (n / SD) % 4;
            exp_digit = 4'hF;
            exp_digit[slot] = 1'b0;
            if (slot >= 1 && LZB && ((m_frame >> (4 * slot)) == 16'h0))
                exp_seg = 8'hFF;
            else
                exp_seg = glyph[(m_frame >> (4 * slot)) & 16'hF];
            exp_tick = ((n % (4 * SD)) == 0);
            if (exp_tick) m_frame = BCD;
            n = (n + 1) % (4 * SD);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            vectors++;
            if (DIGIT !== exp_digit || SEGMENT !== exp_seg || FRAME_TICK !== exp_tick) begin
                miscompares++;
                $display("FAIL model t=%0t: got DIGIT=%b SEGMENT=%h TICK=%b, want DIGIT=%b SEGMENT=%h TICK=%b",
                         $time, DIGIT, SEGMENT, FRAME_TICK, exp_digit, exp_seg, exp_tick);
            end
        end
    end

    // ---------------- directed literal checks ----------------
    task automatic chk(input string name, input logic [3:0] d, input logic [7:0] s, input logic t);
        @(posedge clk);
        #1;
        vectors++;
        if (DIGIT !== d || SEGMENT !== s || FRAME_TICK !== t) begin
            miscompares++;
            $display("FAIL %s: got DIGIT=%b SEGMENT=%h TICK=%b, want DIGIT=%b SEGMENT=%h TICK=%b",
                     name, DIGIT, SEGMENT, FRAME_TICK, d, s, t);
        end
    endtask

    function automatic logic [3:0] sel(input int k);
        logic [3:0] d;
        d = 4'b1111;
        d[k] = 1'b0;
        return d;
    endfunction

    // One full frame: first edge shows the lagging slot-0 glyph s0f.
    task automatic chk_frame(input string name, input logic [7:0] s0f, input logic [7:0] s0,
                             input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        chk(name, sel(0), s0f, 1'b1);
        for (int e = 1; e < 4 * SD; e++)
            chk(name, sel(e / SD), s[e / SD], 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        RST = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        BCD = 16'h1234;
        LZB = 1'b0;

        // Reset state
        @(posedge clk); #1;
        vectors++;
        if (DIGIT !== 4'b1111 || SEGMENT !== 8'hFF || FRAME_TICK !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got DIGIT=%b SEGMENT=%h TICK=%b, want 1111 ff 0", DIGIT, SEGMENT, FRAME_TICK);
        end
        @(posedge clk); #1;
        RST = 1'b0;

        // Basic scan of 1234
        chk_frame("scan1234", 8'hC0, 8'h99, 8'hB0, 8'hA4, 8'hF9);

        // Mid-frame BCD change must not tear the frame
        for (int e = 0; e < 2 * SD; e++)
            chk("notear_a", sel(e / SD), (e < SD) ? 8'h99 : 8'hB0, (e == 0));
        chk("notear_b", 4'b1011, 8'hA4, 1'b0);
        BCD = 16'h5678;
        for (int e = 1; e < SD; e++) chk("notear_c", 4'b1011, 8'hA4, 1'b0);
        for (int e = 0; e < SD; e++) chk("notear_d", 4'b0111, 8'hF9, 1'b0);
        chk("notear_tick", 4'b1110, 8'h99, 1'b1);
        chk("notear_new", 4'b1110, 8'h80, 1'b0);

        // Leading-zero blanking of 0007, then LZB dropped live
        BCD = 16'h0007; LZB = 1'b1;
        do_reset(1);
        chk_frame("lzb_0007", 8'hC0, 8'hF8, 8'hFF, 8'hFF, 8'hFF);
        LZB = 1'b0;
        chk_frame("nolzb_0007", 8'hF8, 8'hF8, 8'hC0, 8'hC0, 8'hC0);

        // Zero score keeps slot 0 lit
        BCD = 16'h0000; LZB = 1'b1;
        do_reset(1);
        chk_frame("lzb_0000", 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        // Dash counts as nonzero for blanking
        BCD = 16'h0A05;
        do_reset(1);
        chk_frame("lzb_0a05", 8'hC0, 8'h92, 8'hC0, 8'hBF, 8'hFF);

        // Reset mid-slot at idx=3, cnt=2
        BCD = 16'h1234; LZB = 1'b0;
        do_reset(1);
        repeat (14) @(posedge clk);
        #1;
        RST = 1'b1;
        BCD = 16'h5678;
        chk("midrst", 4'b1111, 8'hFF, 1'b0);
        RST = 1'b0;
        chk("midrst_reload", 4'b1110, 8'hC0, 1'b1);
        chk("midrst_new", 4'b1110, 8'h80, 1'b0);
        repeat (2 * SD) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
